// File: rtl/fft_stage_sequencer_if.sv
// Handshake and address bus between the FFT stage sequencer and its datapath.
interface fft_stage_sequencer_if #(
  parameter int unsigned N_LOG2 = 4
);
  logic              start;
  logic              busy;
  logic              done;
  logic [N_LOG2-1:0] stage;
  logic [N_LOG2-1:0] sample_addr;
  logic              load_we;
  logic [N_LOG2-1:0] load_waddr;
  logic              bfly_valid;
  logic [N_LOG2-1:0] rd_addr_a;
  logic [N_LOG2-1:0] rd_addr_b;
  logic [N_LOG2-2:0] tw_addr;
  logic              wr_en;
  logic [N_LOG2-1:0] wr_addr_a;
  logic [N_LOG2-1:0] wr_addr_b;

  modport master (
    input  start,
    output busy, done, stage, sample_addr, load_we, load_waddr,
           bfly_valid, rd_addr_a, rd_addr_b, tw_addr,
           wr_en, wr_addr_a, wr_addr_b
  );

  modport slave (
    output start,
    input  busy, done, stage, sample_addr, load_we, load_waddr,
           bfly_valid, rd_addr_a, rd_addr_b, tw_addr,
           wr_en, wr_addr_a, wr_addr_b
  );
endinterface

// File: rtl/fft_stage_sequencer.sv
// Control sequencer for an in-place radix-2 DIT FFT: bit-reversed sample load,
// per-stage butterfly/twiddle address issue, and latency-matched write-back.
module fft_stage_sequencer #(
  parameter int unsigned N_LOG2   = 4,
  parameter int unsigned BFLY_LAT = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  fft_stage_sequencer_if.master bus
);
  localparam int unsigned DW = (BFLY_LAT > 1) ? $clog2(BFLY_LAT) : 1;
  localparam int unsigned DLW = 2 * N_LOG2 + 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t            r_state;
  logic [N_LOG2-1:0] r_cnt;
  logic [N_LOG2-2:0] r_k;
  logic [N_LOG2-1:0] r_stage;
  logic [DW-1:0]     r_drain;
  logic              r_busy;
  logic              r_done;
  logic [N_LOG2-1:0] r_sample_addr;
  logic              r_load_we;
  logic [N_LOG2-1:0] r_load_waddr;
  logic              r_bfly_valid;
  logic [N_LOG2-1:0] r_rd_a;
  logic [N_LOG2-1:0] r_rd_b;
  logic [N_LOG2-2:0] r_tw;
  logic [DLW-1:0]    r_dl [BFLY_LAT];

  logic [N_LOG2-1:0] w_cnt_nxt;
  logic [N_LOG2-2:0] w_k_nxt;
  logic [N_LOG2-1:0] w_stage_nxt;
  logic [DLW-1:0]    w_dl_out;

  assign w_cnt_nxt   = r_cnt + 1'b1;
  assign w_k_nxt     = r_k + 1'b1;
  assign w_stage_nxt = r_stage + 1'b1;

  function automatic logic [N_LOG2-1:0] f_bitrev(input logic [N_LOG2-1:0] v);
    logic [N_LOG2-1:0] w_r;
    for (int unsigned i = 0; i < N_LOG2; i++) w_r[i] = v[N_LOG2-1-i];
    return w_r;
  endfunction

  // Upper operand: grp*2h + pos, with pos = k mod h and grp = k >> s.
  function automatic logic [N_LOG2-1:0] f_rd_a(input logic [N_LOG2-2:0] k,
                                               input logic [N_LOG2-1:0] s);
    logic [N_LOG2-1:0] w_k;
    logic [N_LOG2-1:0] w_pos;
    w_k   = {1'b0, k};
    w_pos = w_k & ((N_LOG2'(1) << s) - N_LOG2'(1));
    return ((w_k >> s) << (s + N_LOG2'(1))) | w_pos;
  endfunction

  // Bit s of the upper operand is always clear, so OR equals +h.
  function automatic logic [N_LOG2-1:0] f_rd_b(input logic [N_LOG2-2:0] k,
                                               input logic [N_LOG2-1:0] s);
    return f_rd_a(k, s) | (N_LOG2'(1) << s);
  endfunction

  function automatic logic [N_LOG2-2:0] f_tw(input logic [N_LOG2-2:0] k,
                                             input logic [N_LOG2-1:0] s);
    logic [N_LOG2-1:0] w_pos;
    logic [N_LOG2-1:0] w_full;
    w_pos  = {1'b0, k} & ((N_LOG2'(1) << s) - N_LOG2'(1));
    w_full = w_pos << (N_LOG2'(N_LOG2 - 1) - s);
    return w_full[N_LOG2-2:0];
  endfunction

  // Sequencer FSM; outputs are registered alongside the state so each one
  // reflects the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_k           <= '0;
      r_stage       <= '0;
      r_drain       <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_sample_addr <= '0;
      r_load_we     <= 1'b0;
      r_load_waddr  <= '0;
      r_bfly_valid  <= 1'b0;
      r_rd_a        <= '0;
      r_rd_b        <= '0;
      r_tw          <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state       <= S_LOAD;
            r_busy        <= 1'b1;
            r_cnt         <= '0;
            r_load_we     <= 1'b1;
            r_sample_addr <= '0;
            r_load_waddr  <= '0;
          end
        end
        S_LOAD: begin
          if (&r_cnt) begin
            r_state       <= S_ISSUE;
            r_cnt         <= '0;
            r_load_we     <= 1'b0;
            r_sample_addr <= '0;
            r_load_waddr  <= '0;
            r_k           <= '0;
            r_stage       <= '0;
            r_bfly_valid  <= 1'b1;
            r_rd_a        <= f_rd_a('0, '0);
            r_rd_b        <= f_rd_b('0, '0);
            r_tw          <= f_tw('0, '0);
          end else begin
            r_cnt         <= w_cnt_nxt;
            r_sample_addr <= w_cnt_nxt;
            r_load_waddr  <= f_bitrev(w_cnt_nxt);
          end
        end
        S_ISSUE: begin
          if (&r_k) begin
            r_state      <= S_DRAIN;
            r_drain      <= '0;
            r_bfly_valid <= 1'b0;
            r_rd_a       <= '0;
            r_rd_b       <= '0;
            r_tw         <= '0;
          end else begin
            r_k    <= w_k_nxt;
            r_rd_a <= f_rd_a(w_k_nxt, r_stage);
            r_rd_b <= f_rd_b(w_k_nxt, r_stage);
            r_tw   <= f_tw(w_k_nxt, r_stage);
          end
        end
        S_DRAIN: begin
          if (r_drain == DW'(BFLY_LAT - 1)) begin
            if (r_stage != N_LOG2'(N_LOG2 - 1)) begin
              r_state      <= S_ISSUE;
              r_stage      <= w_stage_nxt;
              r_k          <= '0;
              r_bfly_valid <= 1'b1;
              r_rd_a       <= f_rd_a('0, w_stage_nxt);
              r_rd_b       <= f_rd_b('0, w_stage_nxt);
              r_tw         <= f_tw('0, w_stage_nxt);
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_stage <= '0;
            end
          end else begin
            r_drain <= r_drain + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Write-back delay line: issued {valid, addr_a, addr_b} retire BFLY_LAT cycles later.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < BFLY_LAT; i++) r_dl[i] <= '0;
    end else begin
      r_dl[0] <= {r_bfly_valid, r_rd_a, r_rd_b};
      for (int unsigned i = 1; i < BFLY_LAT; i++) r_dl[i] <= r_dl[i-1];
    end
  end

  assign w_dl_out = r_dl[BFLY_LAT-1];

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.stage       = r_stage;
  assign bus.sample_addr = r_sample_addr;
  assign bus.load_we     = r_load_we;
  assign bus.load_waddr  = r_load_waddr;
  assign bus.bfly_valid  = r_bfly_valid;
  assign bus.rd_addr_a   = r_rd_a;
  assign bus.rd_addr_b   = r_rd_b;
  assign bus.tw_addr     = r_tw;
  assign bus.wr_en       = w_dl_out[DLW-1];
  assign bus.wr_addr_a   = w_dl_out[2*N_LOG2-1:N_LOG2];
  assign bus.wr_addr_b   = w_dl_out[N_LOG2-1:0];
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench for fft_stage_sequencer at N=16, BFLY_LAT=2.
module tb_fft_stage_sequencer;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  fft_stage_sequencer_if #(.N_LOG2(4)) bus ();

  fft_stage_sequencer #(.N_LOG2(4), .BFLY_LAT(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int br [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  logic       rec_busy [59], rec_done [59], rec_lwe [59], rec_v [59], rec_wen [59];
  logic [3:0] rec_st [59], rec_sa [59], rec_lwa [59], rec_a [59], rec_b [59];
  logic [3:0] rec_wa [59], rec_wb [59];
  logic [2:0] rec_tw [59];

  int exp_v [59], exp_a [59], exp_b [59], exp_tw [59], exp_st [59];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_flags"}, {27'd0, bus.busy, bus.done, bus.load_we, bus.bfly_valid, bus.wr_en}, 32'd0);
    chk({tag, "_addr1"}, {12'd0, bus.stage, bus.sample_addr, bus.load_waddr, bus.rd_addr_a, bus.rd_addr_b}, 32'd0);
    chk({tag, "_addr2"}, {21'd0, bus.tw_addr, bus.wr_addr_a, bus.wr_addr_b}, 32'd0);
  endtask

  task automatic record(input int c);
    rec_busy[c] = bus.busy;      rec_done[c] = bus.done;
    rec_lwe[c]  = bus.load_we;   rec_v[c]    = bus.bfly_valid;
    rec_wen[c]  = bus.wr_en;     rec_st[c]   = bus.stage;
    rec_sa[c]   = bus.sample_addr; rec_lwa[c] = bus.load_waddr;
    rec_a[c]    = bus.rd_addr_a; rec_b[c]    = bus.rd_addr_b;
    rec_tw[c]   = bus.tw_addr;   rec_wa[c]   = bus.wr_addr_a;
    rec_wb[c]   = bus.wr_addr_b;
  endtask

  task automatic check_run(input string nm);
    int k, h, c, nv, nw, last_w, nd;
    for (int i = 0; i < 59; i++) begin
      exp_v[i] = 0; exp_a[i] = 0; exp_b[i] = 0; exp_tw[i] = 0; exp_st[i] = 0;
    end
    // Butterflies enumerated group by group, then position within the group.
    for (int s = 0; s < 4; s++) begin
      h = 1 << s;
      k = 0;
      for (int grp = 0; grp < 8 / h; grp++)
        for (int pos = 0; pos < h; pos++) begin
          c = 17 + 10 * s + k;
          exp_v[c]  = 1;
          exp_a[c]  = grp * 2 * h + pos;
          exp_b[c]  = grp * 2 * h + pos + h;
          exp_tw[c] = pos << (3 - s);
          k++;
        end
      for (int j = 0; j < 10; j++) exp_st[17 + 10 * s + j] = s;
    end
    nv = 0; nw = 0; nd = 0; last_w = -1;
    for (int c2 = 1; c2 <= 58; c2++) begin
      chk($sformatf("%s_busy_c%0d", nm, c2), rec_busy[c2], (c2 <= 57) ? 1 : 0);
      chk($sformatf("%s_done_c%0d", nm, c2), rec_done[c2], (c2 == 57) ? 1 : 0);
      chk($sformatf("%s_lwe_c%0d", nm, c2), rec_lwe[c2], (c2 <= 16) ? 1 : 0);
      chk($sformatf("%s_saddr_c%0d", nm, c2), rec_sa[c2], (c2 <= 16) ? c2 - 1 : 0);
      chk($sformatf("%s_lwaddr_c%0d", nm, c2), rec_lwa[c2], (c2 <= 16) ? br[c2 - 1] : 0);
      chk($sformatf("%s_valid_c%0d", nm, c2), rec_v[c2], exp_v[c2]);
      chk($sformatf("%s_rda_c%0d", nm, c2), rec_a[c2], exp_a[c2]);
      chk($sformatf("%s_rdb_c%0d", nm, c2), rec_b[c2], exp_b[c2]);
      chk($sformatf("%s_tw_c%0d", nm, c2), rec_tw[c2], exp_tw[c2]);
      chk($sformatf("%s_wen_c%0d", nm, c2), rec_wen[c2], (c2 >= 3) ? exp_v[c2 - 2] : 0);
      chk($sformatf("%s_wra_c%0d", nm, c2), rec_wa[c2], (c2 >= 3) ? exp_a[c2 - 2] : 0);
      chk($sformatf("%s_wrb_c%0d", nm, c2), rec_wb[c2], (c2 >= 3) ? exp_b[c2 - 2] : 0);
      if (c2 != 57) chk($sformatf("%s_stage_c%0d", nm, c2), rec_st[c2], exp_st[c2]);
      if (rec_v[c2] === 1'b1) nv++;
      if (rec_wen[c2] === 1'b1) begin nw++; last_w = c2; end
      if (rec_done[c2] === 1'b1) nd++;
    end
    // Hand-derived spot values.
    chk({nm, "_load_c2"},  {rec_sa[2], rec_lwa[2]},   {4'd1, 4'd8});
    chk({nm, "_load_c4"},  {rec_sa[4], rec_lwa[4]},   {4'd3, 4'd12});
    chk({nm, "_load_c16"}, {rec_sa[16], rec_lwa[16]}, {4'd15, 4'd15});
    chk({nm, "_s0k3"}, {rec_a[20], rec_b[20], 1'b0, rec_tw[20]}, {4'd6, 4'd7, 4'd0});
    chk({nm, "_s1k1"}, {rec_a[28], rec_b[28], 1'b0, rec_tw[28]}, {4'd1, 4'd3, 4'd4});
    chk({nm, "_s3k5"}, {rec_a[52], rec_b[52], 1'b0, rec_tw[52]}, {4'd5, 4'd13, 4'd5});
    chk({nm, "_nvalid"}, nv, 32);
    chk({nm, "_nwen"}, nw, 32);
    chk({nm, "_last_wen"}, last_w, 56);
    chk({nm, "_ndone"}, nd, 1);
  endtask

  task automatic do_run(input logic hold, input string nm);
    bus.start = 1'b1;
    tick();
    if (!hold) bus.start = 1'b0;
    for (int c = 1; c <= 58; c++) begin
      record(c);
      if (c < 58) tick();
    end
    check_run(nm);
  endtask

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    tick(); tick();
    chk_zero("in_reset");
    bus.start = 1'b1;
    tick();
    chk_zero("start_during_reset");
    reset     = 1'b0;
    bus.start = 1'b0;
    tick();
    chk_zero("after_reset");
    tick();

    do_run(1'b0, "run_pulse");
    tick(); tick();
    chk_zero("idle_after_pulse");

    do_run(1'b1, "held_a");
    do_run(1'b1, "held_b");
    bus.start = 1'b0;
    tick(); tick();
    chk_zero("idle_after_held");

    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 2; c <= 30; c++) tick();
    chk("mid_stage", bus.stage, 1);
    chk("mid_issue", {bus.bfly_valid, bus.rd_addr_a, bus.rd_addr_b, 1'b0, bus.tw_addr},
        {1'b1, 4'd5, 4'd7, 4'd4});
    reset     = 1'b1;
    bus.start = 1'b1;
    tick();
    chk_zero("abort_c31");
    tick();
    chk_zero("abort_hold");
    reset     = 1'b0;
    bus.start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_zero($sformatf("abort_quiet_%0d", i));
    end

    do_run(1'b0, "post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fft_stage_sequencer.md
Name: fft_stage_sequencer

Overview:
- Control sequencer for the in-place radix-2 decimation-in-time FFT datapath.
- Runs the sample-load phase: reads the input sample ROM and writes the samples to working RAM at bit-reversed addresses.
- Then issues butterfly operand addresses and twiddle ROM addresses (shared cos, cos+sin and cos-sin ROMs) for every stage.
- Delays each butterfly's write-back addresses by the butterfly pipeline latency and inserts drain cycles between stages so no read-after-write hazard reaches the RAM.

Parameters:
- N_LOG2, 4, log2 of FFT size; N = 2^N_LOG2 points, N_LOG2 stages.
- BFLY_LAT, 2, butterfly datapath latency in cycles, from read address to write-back (minimum 1).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  start request; sampled in IDLE only.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the transform is complete.
- stage  output  N_LOG2  index of the stage currently issuing (0..N_LOG2-1).
- sample_addr  output  N_LOG2  input sample ROM address.
- load_we  output  1  write enable for a load-phase RAM write.
- load_waddr  output  N_LOG2  bit-reversed RAM address for the load-phase write.
- bfly_valid  output  1  butterfly operand addresses are valid this cycle.
- rd_addr_a  output  N_LOG2  upper butterfly operand address.
- rd_addr_b  output  N_LOG2  lower butterfly operand address.
- tw_addr  output  N_LOG2-1  twiddle ROM address (3 bits at N=16).
- wr_en  output  1  butterfly result write-back enable.
- wr_addr_a  output  N_LOG2  write-back address for result A.
- wr_addr_b  output  N_LOG2  write-back address for result B.

Behaviour:
- Reset:
  - State goes to IDLE; all counters clear.
  - Write-back delay line is flushed.
  - Every output is 0.
  - Reset mid-operation aborts immediately: no done pulse, no further wr_en.
- States: IDLE -> LOAD -> ISSUE -> DRAIN -> (ISSUE for the next stage | DONE) -> IDLE.
- IDLE:
  - start=1 at edge t0 moves to LOAD.
  - start in any other state is ignored; there is no queuing.
- LOAD (N cycles, t0+1..t0+N):
  - Counter cnt runs 0..N-1.
  - sample_addr=cnt, load_we=1, load_waddr=bitrev(cnt) over N_LOG2 bits.
  - Leaves to ISSUE with stage=0 after cnt=N-1.
- ISSUE (N/2 cycles per stage): butterfly counter k runs 0..N/2-1; with s=stage, h=2^s:
  - pos = k mod h; grp = k >> s.
  - rd_addr_a = grp*2h + pos; rd_addr_b = rd_addr_a + h.
  - tw_addr = pos << (N_LOG2-1-s).
  - bfly_valid=1 every cycle.
  - After k=N/2-1, go to DRAIN.
- DRAIN (BFLY_LAT cycles):
  - bfly_valid=0.
  - The delay line keeps retiring the last writes.
  - Then, if stage<N_LOG2-1: stage increments and the block returns to ISSUE.
  - Otherwise it goes to DONE.
- Write-back:
  - wr_en, wr_addr_a and wr_addr_b equal bfly_valid, rd_addr_a and rd_addr_b delayed by exactly BFLY_LAT cycles (shift register).
  - Every issued butterfly therefore retires before the next stage's first read.
- DONE: done=1 for exactly one cycle, busy=1; next cycle IDLE with busy=0.
- Output defaults: when not asserted, sample_addr, load_waddr, rd_addr_*, tw_addr and stage hold 0; stage is held during DRAIN.
- Timing for N=16, BFLY_LAT=2:
  - Stage s issues t0+17+10s .. t0+24+10s; its wr_en runs t0+19+10s .. t0+26+10s.
  - done at t0+57.
  - busy high t0+1..t0+57.
  - Total length formula: N + N_LOG2*(N/2+BFLY_LAT) + 1 cycles after t0.
- Counters wrap only under FSM control; no address exceeds N-1.
- A start asserted in the same cycle as done, or coincident with reset, is dropped.

Test Plan:
- Reset, then one start pulse -> load_we high 16 cycles; (sample_addr, load_waddr) = (0,0), (1,8), (3,12), (15,15); busy rises at t0+1.
- Stage 0 trace -> k=3 gives rd_a=6, rd_b=7, tw=0; exactly 8 bfly_valid cycles, then 2 idle cycles.
- Stage 1 and stage 3 -> stage 1 k=1 gives rd_a=1, rd_b=3, tw=4; stage 3 k=5 gives rd_a=5, rd_b=13, tw=5.
- Write-back alignment -> every wr_en cycle's wr_addr_a/b equal the rd_addr_a/b from 2 cycles earlier; 32 wr_en cycles in total; the last one is at t0+56; done is a single pulse at t0+57, then busy=0.
- start held high the whole run -> no restart before IDLE; a second run begins at the first IDLE cycle and repeats identical traces.
- reset at t0+30 (stage 1 issuing) -> next cycle all outputs 0, no done pulse and no stray wr_en; a fresh start gives a full correct run.
